// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and helpers for the FIFO drain arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    OUT
  } arb_state_t;

  // Width of the burst counter; BURST_LEN tops out at 255.
  localparam int BURST_W = 8;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    int w;
    w = $clog2(num_ch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// FIFO-side and stream-side signals of the drain arbiter.
interface fifo_drain_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8
) ();
  import fifo_arb_pkg::*;

  localparam int CW = ch_w(NUM_CH);

  logic [NUM_CH-1:0]            fifo_empty;
  logic [NUM_CH-1:0]            fifo_read_en;
  logic [NUM_CH*DATA_WIDTH-1:0] fifo_read_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [CW-1:0]                out_ch;
  logic                         busy;

  // Arbiter side.
  modport master (
    input  fifo_empty, fifo_read_data, out_ready,
    output fifo_read_en, out_valid, out_data, out_ch, busy
  );

  // FIFO bank and consumer side.
  modport slave (
    output fifo_empty, fifo_read_data, out_ready,
    input  fifo_read_en, out_valid, out_data, out_ch, busy
  );

endinterface

// File: rtl/fifo_drain_arbiter_picker.sv
// Round-robin picker: first requesting channel after 'last', wrapping.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     last,
  output logic [CW-1:0]     grant,
  output logic              any_req
);

  logic [2*NUM_CH-1:0] doubled;
  logic [NUM_CH-1:0]   rotated;
  int                  start;
  int                  offset;
  int                  idx;
  logic                found;

  // Rotate the doubled request vector so bit 0 is last+1, then find first.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    doubled = {req, req};
    start   = int'(last) + 1;
    rotated = NUM_CH'(doubled >> start);
    any_req = |req;
    offset  = 0;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && rotated[i]) begin
        offset = i;
        found  = 1'b1;
      end
    end
    idx = start + offset;
    if (idx >= NUM_CH) idx = idx - NUM_CH;
    grant = CW'(idx);
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_CH registered-read FIFOs round-robin into one valid/ready stream.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input logic                  clk,
  input logic                  rst,
  fifo_drain_arbiter_if.master bus
);

  localparam int CW = ch_w(NUM_CH);

  arb_state_t            state;
  arb_state_t            state_next;
  logic [CW-1:0]         grant;
  logic [CW-1:0]         rr_ptr;
  logic [CW-1:0]         pick;
  logic [CW-1:0]         pick_last;
  logic                  any_req;
  logic [BURST_W-1:0]    burst_cnt;
  logic                  stay;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [CW-1:0]         out_ch_q;
  logic [NUM_CH-1:0]     read_en_c;
  logic                  busy_c;

  // At an accept the search restarts after the current grant, otherwise after rr_ptr.
  assign pick_last = (state == OUT) ? grant : rr_ptr;

  // Keep draining the current channel while it has data and the burst is not used up.
  assign stay = !bus.fifo_empty[grant] && (burst_cnt < BURST_W'(BURST_LEN));

  rr_priority_picker #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_picker (
    .req     (~bus.fifo_empty),
    .last    (pick_last),
    .grant   (pick),
    .any_req (any_req)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = READ;
      READ:    state_next = CAPTURE;
      CAPTURE: state_next = OUT;
      OUT:     if (bus.out_ready) state_next = (stay || any_req) ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs: one-hot read strobe during READ, busy outside IDLE.
  always_comb begin
    read_en_c = '0;
    busy_c    = (state != IDLE);
    if (state == READ) read_en_c[grant] = 1'b1;
  end

  // Grant, rotation pointer, burst count and the output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      rr_ptr      <= CW'(NUM_CH - 1);
      burst_cnt   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            burst_cnt <= BURST_W'(1);
          end
        end
        CAPTURE: begin
          out_data_q  <= bus.fifo_read_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
          out_ch_q    <= grant;
          out_valid_q <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (stay) begin
              burst_cnt <= burst_cnt + BURST_W'(1);
            end else begin
              rr_ptr <= grant;
              if (any_req) begin
                grant     <= pick;
                burst_cnt <= BURST_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_read_en = read_en_c;
  assign bus.busy         = busy_c;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_ch       = out_ch_q;

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Round-robin scheduler that drains NUM_CH event FIFOs into one downstream valid/ready stream.
- Each FIFO has a registered read port: data appears the cycle after read_en is asserted while the FIFO is non-empty.
- The block issues read_en to one FIFO at a time, captures the returned word, tags it with its channel index and holds it until the consumer accepts it.
- Sits between the per-channel event FIFOs and the shared convolution engine input.

Parameters:
- NUM_CH, 4, number of FIFOs arbitrated (2..16).
- DATA_WIDTH, 8, FIFO word width.
- BURST_LEN, 4, maximum consecutive words taken from one channel before the grant rotates (1..255).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  NUM_CH  per-channel empty flag.
- fifo_read_en  out  NUM_CH  per-channel read strobe; at most one bit high (one-hot or zero).
- fifo_read_data  in  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data/out_ch hold a word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  DATA_WIDTH  captured word.
- out_ch  out  $clog2(NUM_CH)  source channel of out_data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset values: fifo_read_en=0, out_valid=0, out_data=0, out_ch=0, busy=0, state=IDLE, rr_ptr=NUM_CH-1, burst_cnt=0.
- Clocking and reset: one clock domain only; reset is asynchronous and active-high.
- FSM states: IDLE, READ, CAPTURE, OUT.
- IDLE -> READ when any fifo_empty bit is 0:
  - grant = first non-empty channel searching rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - burst_cnt is loaded with 1.
- READ (1 cycle): fifo_read_en[grant]=1 combinationally from state; go to CAPTURE.
- CAPTURE (1 cycle):
  - out_data <= fifo_read_data[grant], out_ch <= grant, out_valid <= 1.
  - go to OUT.
- OUT: hold out_data, out_ch and out_valid stable while out_ready=0. On out_ready=1:
  - out_valid <= 0 on the same edge.
  - If !fifo_empty[grant] and burst_cnt < BURST_LEN: stay on grant, burst_cnt++, next state READ.
  - Else: rr_ptr <= grant; if any other or the same channel is non-empty, re-arbitrate from grant+1, burst_cnt <= 1, next state READ; otherwise next state IDLE.
  - The rotation search may wrap back to grant itself if it is the only non-empty channel.
- Latency and throughput:
  - FIFO non-empty to out_valid: 3 cycles from IDLE (IDLE, READ, CAPTURE edges).
  - Sustained throughput: 1 word per 3 cycles with out_ready held at 1.
- Empty sampling: fifo_empty is sampled only at IDLE and at OUT-accept decisions. It reflects the post-read pointer because the FIFO updates its pointer on the READ edge.
- No read_en is ever issued to a channel whose fifo_empty=1 in that cycle.
- rr_ptr wrap: after channel NUM_CH-1 the search continues at 0.
- Backpressure: out_ready low for any length never causes an extra read; only one word is ever in flight.
- Reset asserted mid-operation: all state clears immediately. A word read in READ but not yet captured is dropped. This is accepted; flush is system-level.
- Simultaneous events: a new channel going non-empty in the same cycle as an accept is eligible for that arbitration.

Decomposition:
- Package fifo_arb_pkg:
  - state enum arb_state_t {IDLE, READ, CAPTURE, OUT}.
  - function ch_w(NUM_CH) returning max(1, $clog2(NUM_CH)).
  - BURST_W = 8.
- Sub-module rr_priority_picker (combinational):
  - inputs: request vector, last pointer.
  - outputs: grant index, any_req.
  - implemented with a doubled-vector rotate-and-find-first.

Test Plan:
- Single request: reset, fifo 2 holds 0xA5, others empty, out_ready=1 -> fifo_read_en=4'b0100 for exactly 1 cycle; out_valid with out_data=0xA5, out_ch=2 three cycles after release from IDLE; then IDLE with busy=0.
- Round-robin: BURST_LEN=1, all 4 FIFOs hold 3 words, out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3 with no duplicates or losses.
- Burst: BURST_LEN=4, ch0 holds 6 words, ch1 holds 2 -> out_ch 0,0,0,0,1,1,0,0.
- Backpressure: out_ready=0 for 10 cycles with a word captured -> out_data/out_ch stable, fifo_read_en stays 0; the word is delivered once when out_ready rises.
- Wrap and last word: rr_ptr=3, only ch3 non-empty with 1 word -> grant ch3; after accept fifo_empty[3]=1, FSM returns to IDLE with no read to an empty FIFO.
- Reset mid-burst: assert rst during CAPTURE -> out_valid=0 and fifo_read_en=0 immediately; after release, arbitration restarts from ch0.
